sram22_arb2_ctrl: RTL and testbench
===================================

Name: sram22_arb2_ctrl

Overview:
- Sequencer and 2-requester round-robin arbiter in front of one single-port SRAM22 macro (256 words x 16 bits, 8-bit write granularity).
- After reset it optionally zero-fills the whole array.
- It then shares the macro between two requesters using valid/ready request handshakes.
- Read data returns on a per-requester response port with fixed 1-cycle latency.

Parameters:
- ADDR_WIDTH, 8, macro address width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 16, word width.
- WMASK_WIDTH, 2, write-mask bits; each bit covers DATA_WIDTH/WMASK_WIDTH bits, LSB = bits [7:0].
- INIT_EN, 1, 1 = zero-fill array after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rstb  in  1  reset, synchronous, active-low.
- init_done  out  1  high once RUN is entered.
- reqN_valid  in  1  request valid (N = 0,1).
- reqN_ready  out  1  request accepted this cycle.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_wmask  in  WMASK_WIDTH  byte-lane enables for writes.
- reqN_addr  in  ADDR_WIDTH  word address.
- reqN_wdata  in  DATA_WIDTH  write data.
- rspN_valid  out  1  read data valid, one-cycle pulse.
- rspN_rdata  out  DATA_WIDTH  read data.
- sram_rstb  out  1  macro reset; equals rstb.
- sram_ce  out  1  macro chip enable.
- sram_we  out  1  macro write enable.
- sram_wmask  out  WMASK_WIDTH  macro write mask.
- sram_addr  out  ADDR_WIDTH  macro address.
- sram_din  out  DATA_WIDTH  macro write data.
- sram_dout  in  DATA_WIDTH  macro read data, registered inside the macro.

Behaviour:
- Reset: rstb low at a posedge sets:
  - state = INIT (INIT_EN=1) or RUN (INIT_EN=0)
  - init_cnt = 0, rr_ptr = 0, rd_pend = 0
  - init_done = 0 when INIT_EN=1; init_done = 1 when INIT_EN=0 (applied at that reset edge)
  - rspN_valid = 0
- While rstb is low: reqN_ready = 0 and sram_ce = 0 (combinational gating).
- INIT state:
  - Each cycle: sram_ce=1, sram_we=1, sram_wmask=all ones, sram_addr=init_cnt, sram_din=0; init_cnt increments.
  - The cycle with init_cnt = 2^ADDR_WIDTH-1 is the last write. At that edge: state -> RUN, init_done -> 1.
  - Net effect: cycle k after reset release writes address k; first request accept possible in cycle 2^ADDR_WIDTH (cycle 256).
  - reqN_ready = 0 throughout INIT; requests are held by the requester, never dropped.
- RUN arbitration (combinational grant):
  - Only one reqN_valid high: grant N.
  - Both high: grant rr_ptr.
  - Neither high: no grant; sram_ce = 0.
  - reqN_ready = RUN & grant==N. ready may depend combinationally on valid.
  - After any grant, rr_ptr <= 1 - granted index.
- Issue: the accept cycle is the issue cycle.
  - sram_ce=1; sram_we/wmask/addr/din = granted request's fields, forwarded combinationally.
  - The macro samples them at the same posedge.
- Reads:
  - rd_pend[N] <= 1 at accept of a read.
  - rspN_valid = registered rd_pend; high exactly the cycle after accept.
  - rspN_rdata = sram_dout while rspN_valid. No response backpressure; the requester must take the data.
  - Back-to-back reads from either port are supported every cycle.
- Writes:
  - No response.
  - wmask=0 is still accepted and consumes the slot; memory unchanged.
  - A partial mask leaves unmasked lanes unchanged.
- Ordering:
  - Operations execute strictly in grant order.
  - A write by port 1 granted before a read by port 0 of the same address is visible to that read; the reverse order returns old data.
- Reset mid-operation:
  - Mid-INIT: init_cnt restarts at 0; full fill repeats.
  - Read accepted in the cycle of the reset edge: response dropped, rspN_valid stays 0.
- rspN_rdata while rspN_valid=0: don't-care. Benches must not check it.

Test Plan:
- INIT_EN=1, release rstb, no requests -> sram_ce=1 for exactly 256 cycles, addresses 0x00..0xFF in order, din=0; init_done rises at the end of cycle 255. Then reads of 0x00, 0x7F, 0xFF -> rdata 0x0000 one cycle later.
- req0 write addr 0x12 data 0xBEEF wmask 2'b11, then req0 read 0x12 -> rsp0_valid exactly one cycle after read accept, rdata 0xBEEF; rsp1_valid stays 0.
- Zeroed addr 0x05: write 0x1234 mask 2'b01, read -> 0x0034. Then write 0xAB00 mask 2'b10, read -> 0xAB34. Then write 0xFFFF mask 2'b00, read -> 0xAB34.
- rr_ptr=0, both ports hold valid reads for 4 cycles (req0 addr 0x01, req1 addr 0x02, preloaded 0x1111/0x2222) -> grants 0,1,0,1; rsp0 and rsp1 alternate with 0x1111 and 0x2222 respectively.
- Same cycle: req1 write 0x40=0x5A5A and req0 read 0x40, rr_ptr=1 -> req1 granted first; req0 read accepted next cycle, returns 0x5A5A.
- Two cases:
  - rstb low at init_cnt=100 -> init_done=0; fill restarts at addr 0x00 and takes 256 more cycles.
  - rstb low in the cycle a read is accepted -> no rspN_valid pulse.

Source files
------------

// File: rtl/sram22_arb2_ctrl.sv
// Zero-fill sequencer plus 2-port round-robin arbiter in front of a single-port SRAM22 macro.
// Latency: request issued to the macro in its accept cycle; read data returned exactly one cycle later.
// Backpressure: reqN_ready low during reset/fill or when the other port wins; responses cannot be stalled.
module sram22_arb2_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int WMASK_WIDTH = 2,
    parameter int INIT_EN     = 1
) (
    input  logic                   clk,
    input  logic                   rstb,
    output logic                   init_done,

    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic                   req0_we,
    input  logic [WMASK_WIDTH-1:0] req0_wmask,
    input  logic [ADDR_WIDTH-1:0]  req0_addr,
    input  logic [DATA_WIDTH-1:0]  req0_wdata,
    output logic                   rsp0_valid,
    output logic [DATA_WIDTH-1:0]  rsp0_rdata,

    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic                   req1_we,
    input  logic [WMASK_WIDTH-1:0] req1_wmask,
    input  logic [ADDR_WIDTH-1:0]  req1_addr,
    input  logic [DATA_WIDTH-1:0]  req1_wdata,
    output logic                   rsp1_valid,
    output logic [DATA_WIDTH-1:0]  rsp1_rdata,

    output logic                   sram_rstb,
    output logic                   sram_ce,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Reset lands in the fill sequence only when zero-fill is enabled.
    localparam state_t                RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;
    localparam logic                  RST_DONE  = (INIT_EN == 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  rr_ptr;
    logic [1:0]            rd_pend;

    logic                  gnt_vld;
    logic                  gnt_idx;
    logic                  fill_last;

    assign fill_last = (state == ST_INIT) && (init_cnt == LAST_ADDR);

    // Grant selection: a lone requester wins outright, a tie goes to rr_ptr.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        if (rstb && (state == ST_RUN)) begin
            if (req0_valid && req1_valid) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_ptr;
            end else if (req0_valid) begin
                gnt_vld = 1'b1;
                gnt_idx = 1'b0;
            end else if (req1_valid) begin
                gnt_vld = 1'b1;
                gnt_idx = 1'b1;
            end
        end
    end

    // State register: fill sequence, then run forever until the next reset.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave the fill once the top address has been written.
    always_comb begin
        state_nxt = state;
        if (fill_last) begin
            state_nxt = ST_RUN;
        end
    end

    // Fill counter, round-robin pointer, read-pending flags and init_done.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            init_cnt  <= '0;
            rr_ptr    <= 1'b0;
            rd_pend   <= 2'b00;
            init_done <= RST_DONE;
        end else begin
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
            if (fill_last) begin
                init_done <= 1'b1;
            end
            if (gnt_vld) begin
                rr_ptr <= ~gnt_idx;
            end
            // The macro registers read data, so a pending flag lines up with sram_dout next cycle.
            rd_pend[0] <= gnt_vld && !gnt_idx && !req0_we;
            rd_pend[1] <= gnt_vld &&  gnt_idx && !req1_we;
        end
    end

    // Macro drive and ready: fill writes during INIT, granted request forwarded during RUN.
    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_wmask = '0;
        sram_addr  = '0;
        sram_din   = '0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rstb) begin
            if (state == ST_INIT) begin
                sram_ce    = 1'b1;
                sram_we    = 1'b1;
                sram_wmask = '1;
                sram_addr  = init_cnt;
                sram_din   = '0;
            end else if (gnt_vld) begin
                sram_ce = 1'b1;
                if (gnt_idx) begin
                    sram_we    = req1_we;
                    sram_wmask = req1_wmask;
                    sram_addr  = req1_addr;
                    sram_din   = req1_wdata;
                    req1_ready = 1'b1;
                end else begin
                    sram_we    = req0_we;
                    sram_wmask = req0_wmask;
                    sram_addr  = req0_addr;
                    sram_din   = req0_wdata;
                    req0_ready = 1'b1;
                end
            end
        end
    end

    assign sram_rstb  = rstb;
    assign rsp0_valid = rd_pend[0];
    assign rsp1_valid = rd_pend[1];
    assign rsp0_rdata = sram_dout;
    assign rsp1_rdata = sram_dout;

endmodule

// File: tb/tb_sram22_arb2_ctrl.sv
// Bench for sram22_arb2_ctrl: behavioural SRAM macro, reference model, directed and random stimulus.
// Latency: inputs driven 1 time unit after posedge, outputs compared on negedge.
// Backpressure: requests held until ready; responses taken unconditionally.
module tb_sram22_arb2_ctrl;

    logic        clk = 1'b0;
    logic        rstb;
    logic        init_done;
    logic        req0_valid, req0_ready, req0_we;
    logic [1:0]  req0_wmask;
    logic [7:0]  req0_addr;
    logic [15:0] req0_wdata;
    logic        rsp0_valid;
    logic [15:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [1:0]  req1_wmask;
    logic [7:0]  req1_addr;
    logic [15:0] req1_wdata;
    logic        rsp1_valid;
    logic [15:0] rsp1_rdata;
    logic        sram_rstb, sram_ce, sram_we;
    logic [1:0]  sram_wmask;
    logic [7:0]  sram_addr;
    logic [15:0] sram_din;
    logic [15:0] sram_dout;

    always #5 clk = ~clk;

    sram22_arb2_ctrl #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .WMASK_WIDTH(2), .INIT_EN(1)
    ) dut (
        .clk(clk), .rstb(rstb), .init_done(init_done),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_wmask(req0_wmask), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_wmask(req1_wmask), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .sram_rstb(sram_rstb), .sram_ce(sram_ce), .sram_we(sram_we),
        .sram_wmask(sram_wmask), .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_dout(sram_dout)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] m);
        logic [15:0] r;
        r = old;
        if (m[0]) r[7:0]  = nw[7:0];
        if (m[1]) r[15:8] = nw[15:8];
        return r;
    endfunction

    // Behavioural macro: registered read, byte-masked write, starts full of garbage.
    logic [15:0] smem [256];
    initial for (int i = 0; i < 256; i++) smem[i] = 16'($urandom);
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) smem[sram_addr] = merge(smem[sram_addr], sram_din, sram_wmask);
            else         sram_dout <= smem[sram_addr];
        end
    end

    // Reference model: fill position, golden memory, last-granted port, pending responses.
    logic [15:0] gmem [256];
    int          fill_idx = 0;
    bit          run  = 1'b0;
    bit          done = 1'b0;
    bit          ptr  = 1'b0;
    bit          pend [2] = '{1'b0, 1'b0};
    logic [15:0] pdat [2];

    always @(negedge clk) begin : compare
        bit          v [2];
        bit          w [2];
        logic [1:0]  m [2];
        logic [7:0]  a [2];
        logic [15:0] d [2];
        int          g;
        if (chk_en) begin
            v[0] = req0_valid; w[0] = req0_we; m[0] = req0_wmask; a[0] = req0_addr; d[0] = req0_wdata;
            v[1] = req1_valid; w[1] = req1_we; m[1] = req1_wmask; a[1] = req1_addr; d[1] = req1_wdata;
            chk("rsp0_valid", rsp0_valid, pend[0]);
            if (pend[0]) chk("rsp0_rdata", rsp0_rdata, pdat[0]);
            chk("rsp1_valid", rsp1_valid, pend[1]);
            if (pend[1]) chk("rsp1_rdata", rsp1_rdata, pdat[1]);
            chk("init_done", init_done, done);
            chk("sram_rstb", sram_rstb, rstb);
            pend[0] = 1'b0;
            pend[1] = 1'b0;
            if (!rstb) begin
                chk("rst_ce", sram_ce, 0);
                chk("rst_ready0", req0_ready, 0);
                chk("rst_ready1", req1_ready, 0);
                fill_idx = 0; run = 1'b0; done = 1'b0; ptr = 1'b0;
            end else if (!run) begin
                chk("fill_ce", sram_ce, 1);
                chk("fill_we", sram_we, 1);
                chk("fill_wmask", sram_wmask, 2'b11);
                chk("fill_addr", sram_addr, fill_idx);
                chk("fill_din", sram_din, 0);
                chk("fill_ready0", req0_ready, 0);
                chk("fill_ready1", req1_ready, 0);
                gmem[fill_idx] = 16'h0000;
                if (fill_idx == 255) begin
                    run = 1'b1; done = 1'b1;
                end
                fill_idx++;
            end else begin
                g = -1;
                if (v[0] && v[1]) g = int'(ptr);
                else if (v[0])    g = 0;
                else if (v[1])    g = 1;
                chk("ready0", req0_ready, g == 0);
                chk("ready1", req1_ready, g == 1);
                chk("ce", sram_ce, g >= 0);
                if (g >= 0) begin
                    chk("we", sram_we, w[g]);
                    chk("addr", sram_addr, a[g]);
                    if (w[g]) begin
                        chk("wmask", sram_wmask, m[g]);
                        chk("din", sram_din, d[g]);
                        gmem[a[g]] = merge(gmem[a[g]], d[g], m[g]);
                    end else begin
                        pend[g] = 1'b1;
                        pdat[g] = gmem[a[g]];
                    end
                    ptr = (g == 0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input bit vl, input bit we, input logic [1:0] m,
                            input logic [7:0] a, input logic [15:0] d);
        if (p == 0) begin
            req0_valid = vl; req0_we = we; req0_wmask = m; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = vl; req1_we = we; req1_wmask = m; req1_addr = a; req1_wdata = d;
        end
    endtask

    // One request on port p; for reads, the response is checked against a literal.
    task automatic do_op(input int p, input bit we, input logic [1:0] m, input logic [7:0] a,
                         input logic [15:0] d, input logic [15:0] exp);
        bit acc;
        acc = 1'b0;
        set_port(p, 1'b1, we, m, a, d);
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk);
            acc = (p == 0) ? req0_ready : req1_ready;
            step();
        end
        set_port(p, 1'b0, we, m, a, d);
        chk("accept_in_budget", acc, 1);
        if (!we) begin
            @(negedge clk);
            chk("lit_rsp_valid", (p == 0) ? rsp0_valid : rsp1_valid, 1);
            chk("lit_rsp_rdata", (p == 0) ? rsp0_rdata : rsp1_rdata, exp);
            chk("lit_other_rsp", (p == 0) ? rsp1_valid : rsp0_valid, 0);
            step();
        end
    endtask

    // Counts fill cycles from the current cycle until init_done is seen.
    task automatic wait_init(input string nm);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (init_done) break;
            cnt++;
        end
        step();
        chk(nm, cnt, 256);
    endtask

    initial begin
        rstb = 1'b0;
        set_port(0, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
        set_port(1, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
        @(posedge clk);
        #1 chk_en = 1'b1;
        step();
        step();

        // Fill interrupted at address 100, then a complete fill.
        rstb = 1'b1;
        repeat (100) step();
        chk("mid_fill_init_done", init_done, 0);
        chk("mid_fill_addr", sram_addr, 100);
        rstb = 1'b0;
        step();
        rstb = 1'b1;
        wait_init("fill_cycles_after_restart");

        do_op(0, 1'b0, 2'b00, 8'h00, 16'h0, 16'h0000);
        do_op(1, 1'b0, 2'b00, 8'h7F, 16'h0, 16'h0000);
        do_op(0, 1'b0, 2'b00, 8'hFF, 16'h0, 16'h0000);

        do_op(0, 1'b1, 2'b11, 8'h12, 16'hBEEF, 16'h0);
        do_op(0, 1'b0, 2'b00, 8'h12, 16'h0, 16'hBEEF);

        do_op(0, 1'b1, 2'b01, 8'h05, 16'h1234, 16'h0);
        do_op(0, 1'b0, 2'b00, 8'h05, 16'h0, 16'h0034);
        do_op(0, 1'b1, 2'b10, 8'h05, 16'hAB00, 16'h0);
        do_op(0, 1'b0, 2'b00, 8'h05, 16'h0, 16'hAB34);
        do_op(0, 1'b1, 2'b00, 8'h05, 16'hFFFF, 16'h0);
        do_op(0, 1'b0, 2'b00, 8'h05, 16'h0, 16'hAB34);

        // Preload; port 1 goes last so the tie-break points at port 0.
        do_op(0, 1'b1, 2'b11, 8'h01, 16'h1111, 16'h0);
        do_op(1, 1'b1, 2'b11, 8'h02, 16'h2222, 16'h0);
        set_port(0, 1'b1, 1'b0, 2'b00, 8'h01, 16'h0);
        set_port(1, 1'b1, 1'b0, 2'b00, 8'h02, 16'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                chk("rr_ready0", req0_ready, (i % 2) == 0);
                chk("rr_ready1", req1_ready, (i % 2) == 1);
            end
            if (i >= 1) begin
                if (((i - 1) % 2) == 0) begin
                    chk("rr_rsp0_valid", rsp0_valid, 1);
                    chk("rr_rsp0_rdata", rsp0_rdata, 16'h1111);
                end else begin
                    chk("rr_rsp1_valid", rsp1_valid, 1);
                    chk("rr_rsp1_rdata", rsp1_rdata, 16'h2222);
                end
            end
            step();
            if (i == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end

        // Port 0 goes last so the tie-break points at port 1.
        do_op(0, 1'b0, 2'b00, 8'h01, 16'h0, 16'h1111);
        set_port(1, 1'b1, 1'b1, 2'b11, 8'h40, 16'h5A5A);
        set_port(0, 1'b1, 1'b0, 2'b00, 8'h40, 16'h0);
        @(negedge clk);
        chk("wr_first_ready1", req1_ready, 1);
        chk("wr_first_ready0", req0_ready, 0);
        step();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("rd_second_ready0", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("raw_rsp0_valid", rsp0_valid, 1);
        chk("raw_rsp0_rdata", rsp0_rdata, 16'h5A5A);
        step();

        // Read presented in a reset cycle produces no response.
        set_port(0, 1'b1, 1'b0, 2'b00, 8'h40, 16'h0);
        rstb = 1'b0;
        @(negedge clk);
        chk("rst_read_ready0", req0_ready, 0);
        step();
        req0_valid = 1'b0;
        rstb = 1'b1;
        chk("rst_read_no_rsp", rsp0_valid, 0);
        chk("rst_read_init_done", init_done, 0);
        wait_init("fill_cycles_after_rst_read");

        // Random traffic over a small address window to force address reuse.
        for (int i = 0; i < 1500; i++) begin
            set_port(0, $urandom_range(0, 9) < 7, 1'($urandom), 2'($urandom),
                     8'($urandom_range(0, 15)), 16'($urandom));
            set_port(1, $urandom_range(0, 9) < 7, 1'($urandom), 2'($urandom),
                     8'($urandom_range(0, 15)), 16'($urandom));
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
